// File: rtl/saf_train_ctrl_if.sv
// rtl/saf_train_ctrl_if.sv - command/control bundle between host and the SAF training sequencer
// master: host side, drives start/freeze/abort/n_train and observes datapath controls and status.
// slave : sequencer side, the mirror image.
`timescale 1ns/1ps
interface saf_train_ctrl_if #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 24,
  parameter int SPAN_WIDTH = 5,
  parameter int LIN_AW     = 5
);
  logic                  start;
  logic                  freeze;
  logic                  abort;
  logic [CNT_W-1:0]      n_train;
  logic                  dp_reset;
  logic                  lut_wr_en;
  logic [SPAN_WIDTH-1:0] lut_wr_addr;
  logic [WIDTH-1:0]      lut_wr_data;
  logic                  lin_wr_en;
  logic [LIN_AW-1:0]     lin_wr_addr;
  logic [WIDTH-1:0]      lin_wr_data;
  logic                  adapt_en;
  logic                  out_valid;
  logic                  busy;
  logic                  done;
  logic [2:0]            state;
  logic [CNT_W-1:0]      train_cnt;

  modport master (
    output start, freeze, abort, n_train,
    input  dp_reset, lut_wr_en, lut_wr_addr, lut_wr_data, lin_wr_en, lin_wr_addr, lin_wr_data,
    input  adapt_en, out_valid, busy, done, state, train_cnt
  );

  modport slave (
    input  start, freeze, abort, n_train,
    output dp_reset, lut_wr_en, lut_wr_addr, lut_wr_data, lin_wr_en, lin_wr_addr, lin_wr_data,
    output adapt_en, out_valid, busy, done, state, train_cnt
  );
endinterface

// File: rtl/saf_train_ctrl.sv
// rtl/saf_train_ctrl.sv - init/flush/train sequencer for the Hammerstein SAF-LMS datapath
// Ports: clk; reset (synchronous, active-low); bus (slave modport) carrying the
// start/freeze/abort/n_train commands in and dp_reset, spline LUT and FIR tap write
// ports, adapt_en, out_valid, busy, done, state and train_cnt out. All outputs registered.
`timescale 1ns/1ps
module saf_train_ctrl #(
  parameter int L_ORD      = 32,
  parameter int Q          = 13,
  parameter int Q_ORD      = 4,
  parameter int WIDTH      = 16,
  parameter int QP         = 12,
  parameter int DelX_inv   = 2,
  parameter int FLUSH_LEN  = 6,
  parameter int CNT_W      = 24,
  parameter int SPAN_WIDTH = $clog2(Q + Q_ORD)
) (
  input logic           clk,
  input logic           reset,
  saf_train_ctrl_if.slave bus
);
  localparam int LIN_AW = $clog2(L_ORD);
  localparam int FL_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int SHIFT  = QP - DelX_inv;
  localparam int MID    = (Q - 1) / 2;
  localparam logic [WIDTH-1:0] TAP0 = WIDTH'(1) << QP;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT_Q = 3'd1,
    S_INIT_W = 3'd2,
    S_FLUSH  = 3'd3,
    S_TRAIN  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  // Identity spline: control point k sits at x = (k - MID) * DelX, so y = x there.
  function automatic logic [WIDTH-1:0] lut_val(input logic [SPAN_WIDTH-1:0] k);
    logic signed [31:0] v;
    v = $signed(32'(k)) - 32'(MID);
    v = v <<< SHIFT;
    return v[WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic                  lut_wr_en_q, lut_wr_en_d;
  logic [SPAN_WIDTH-1:0] lut_wr_addr_q, lut_wr_addr_d;
  logic [WIDTH-1:0]      lut_wr_data_q, lut_wr_data_d;
  logic                  lin_wr_en_q, lin_wr_en_d;
  logic [LIN_AW-1:0]     lin_wr_addr_q, lin_wr_addr_d;
  logic [WIDTH-1:0]      lin_wr_data_q, lin_wr_data_d;
  logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]      train_cnt_q, train_cnt_d;
  logic [CNT_W-1:0]      n_train_q, n_train_d;
  logic                  dp_reset_q, adapt_en_q, out_valid_q, busy_q, done_q;

  always_comb begin
    state_d       = state_q;
    lut_wr_en_d   = 1'b0;
    lut_wr_addr_d = '0;
    lut_wr_data_d = '0;
    lin_wr_en_d   = 1'b0;
    lin_wr_addr_d = '0;
    lin_wr_data_d = '0;
    flush_cnt_d   = flush_cnt_q;
    train_cnt_d   = train_cnt_q;
    n_train_d     = n_train_q;

    if (bus.abort && state_q != S_IDLE) begin
      // Any write in flight is simply not issued on the next cycle.
      state_d     = S_IDLE;
      flush_cnt_d = '0;
      train_cnt_d = '0;
      n_train_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d       = S_INIT_Q;
            lut_wr_en_d   = 1'b1;
            lut_wr_data_d = lut_val('0);
          end
        end
        S_INIT_Q: begin
          if (lut_wr_addr_q == SPAN_WIDTH'(Q - 1)) begin
            state_d       = S_INIT_W;
            lin_wr_en_d   = 1'b1;
            lin_wr_data_d = TAP0;
          end else begin
            lut_wr_en_d   = 1'b1;
            lut_wr_addr_d = lut_wr_addr_q + SPAN_WIDTH'(1);
            lut_wr_data_d = lut_val(lut_wr_addr_q + SPAN_WIDTH'(1));
          end
        end
        S_INIT_W: begin
          if (lin_wr_addr_q == LIN_AW'(L_ORD - 1)) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end else begin
            lin_wr_en_d   = 1'b1;
            lin_wr_addr_d = lin_wr_addr_q + LIN_AW'(1);
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == FL_W'(FLUSH_LEN - 1)) begin
            state_d     = S_TRAIN;
            train_cnt_d = '0;
            n_train_d   = bus.n_train;
          end else begin
            flush_cnt_d = flush_cnt_q + FL_W'(1);
          end
        end
        S_TRAIN: begin
          // The counter does not advance on the exit edge, so HOLD shows n_train-1.
          if (bus.freeze || (n_train_q != '0 && train_cnt_q == n_train_q - CNT_W'(1))) begin
            state_d = S_HOLD;
          end else if (train_cnt_q != '1) begin
            train_cnt_d = train_cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.start) begin
            state_d     = S_TRAIN;
            train_cnt_d = '0;
            n_train_d   = bus.n_train;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      lut_wr_en_q   <= 1'b0;
      lut_wr_addr_q <= '0;
      lut_wr_data_q <= '0;
      lin_wr_en_q   <= 1'b0;
      lin_wr_addr_q <= '0;
      lin_wr_data_q <= '0;
      flush_cnt_q   <= '0;
      train_cnt_q   <= '0;
      n_train_q     <= '0;
      dp_reset_q    <= 1'b1;
      adapt_en_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lut_wr_en_q   <= lut_wr_en_d;
      lut_wr_addr_q <= lut_wr_addr_d;
      lut_wr_data_q <= lut_wr_data_d;
      lin_wr_en_q   <= lin_wr_en_d;
      lin_wr_addr_q <= lin_wr_addr_d;
      lin_wr_data_q <= lin_wr_data_d;
      flush_cnt_q   <= flush_cnt_d;
      train_cnt_q   <= train_cnt_d;
      n_train_q     <= n_train_d;
      // Status flags are decoded from the next state so they line up with state_q.
      dp_reset_q    <= (state_d == S_IDLE);
      adapt_en_q    <= (state_d == S_TRAIN);
      out_valid_q   <= (state_d == S_TRAIN) || (state_d == S_HOLD);
      busy_q        <= (state_d == S_INIT_Q) || (state_d == S_INIT_W) || (state_d == S_FLUSH);
      done_q        <= (state_d == S_HOLD);
    end
  end

  assign bus.dp_reset    = dp_reset_q;
  assign bus.lut_wr_en   = lut_wr_en_q;
  assign bus.lut_wr_addr = lut_wr_addr_q;
  assign bus.lut_wr_data = lut_wr_data_q;
  assign bus.lin_wr_en   = lin_wr_en_q;
  assign bus.lin_wr_addr = lin_wr_addr_q;
  assign bus.lin_wr_data = lin_wr_data_q;
  assign bus.adapt_en    = adapt_en_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state       = state_q;
  assign bus.train_cnt   = train_cnt_q;
endmodule

// File: tb/tb_saf_train_ctrl.sv
// tb/tb_saf_train_ctrl.sv - scoreboard bench for saf_train_ctrl
`timescale 1ns/1ps
module tb_saf_train_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  saf_train_ctrl_if bus();

  saf_train_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_lin;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Expected write stream of a full init: 13 spline points on the y=x line
  // spaced by 1/4 in Q12, then a unit-impulse FIR.
  task automatic push_init();
    wr_t w;
    int  v;
    for (int k = 0; k < 13; k++) begin
      v        = (k - 6) * 1024;
      w.is_lin = 1'b0;
      w.addr   = 8'(k);
      w.data   = v[15:0];
      exp_q.push_back(w);
    end
    for (int j = 0; j < 32; j++) begin
      w.is_lin = 1'b1;
      w.addr   = 8'(j);
      w.data   = (j == 0) ? 16'h1000 : 16'h0000;
      exp_q.push_back(w);
    end
  endtask

  // Write monitor: every strobe pops one expected write.
  always @(negedge clk) begin
    wr_t got;
    wr_t e;
    if (bus.lut_wr_en || bus.lin_wr_en) begin
      got.is_lin = bus.lin_wr_en;
      got.addr   = bus.lin_wr_en ? 8'(bus.lin_wr_addr) : 8'(bus.lut_wr_addr);
      got.data   = bus.lin_wr_en ? bus.lin_wr_data : bus.lut_wr_data;
      n_checks++;
      if (bus.lut_wr_en && bus.lin_wr_en) begin
        n_fail++;
        $display("FAIL both_strobes: actual lut=1 lin=1 required at most one");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: actual lin=%0d addr=%0d data=%h required no write",
                 got.is_lin, got.addr, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL write_stream: actual lin=%0d addr=%0d data=%h required lin=%0d addr=%0d data=%h",
                   got.is_lin, got.addr, got.data, e.is_lin, e.addr, e.data);
        end
      end
    end
  end

  // Start from IDLE; counts edges with the start-sampling edge as edge 1.
  // Injects a freeze during INIT_W and a start during FLUSH, both of which must be ignored.
  task automatic run_init(input int ntr);
    int e;
    int fz_at;
    int st_at;
    push_init();
    fz_at       = int'($urandom_range(15, 40));
    st_at       = int'($urandom_range(46, 49));
    bus.n_train = 24'(ntr);
    bus.start   = 1'b1;
    tick();
    e         = 1;
    bus.start = 1'b0;
    check("initq_state", bus.state, 1);
    check("initq_busy", bus.busy, 1);
    check("initq_dp_reset", bus.dp_reset, 0);
    while (!bus.adapt_en && e < 200) begin
      bus.freeze = (e == fz_at);
      bus.start  = (e == st_at);
      tick();
      e++;
    end
    bus.freeze = 1'b0;
    bus.start  = 1'b0;
    check("adapt_rise_edge", e, 52);
    check("init_writes_left", exp_q.size(), 0);
    check("train_entry_state", bus.state, 4);
    check("train_entry_cnt", bus.train_cnt, 0);
  endtask

  task automatic resume(input int ntr);
    bus.n_train = 24'(ntr);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check("resume_state", bus.state, 4);
    check("resume_cnt", bus.train_cnt, 0);
    check("resume_adapt", bus.adapt_en, 1);
  endtask

  // Called in the first TRAIN cycle. Reference: adaptation lasts n_train cycles,
  // or fz cycles if a freeze comes earlier (freeze on the terminal cycle counts once).
  task automatic train_episode(input int ntr, input int fz, input bit chg);
    int cyc;
    int exp_len;
    exp_len = (ntr != 0 && (fz == 0 || ntr <= fz)) ? ntr : fz;
    cyc = 1;
    while (bus.adapt_en && cyc < 3000) begin
      bus.freeze = (fz != 0 && cyc == fz);
      if (chg && cyc == 2) bus.n_train = 24'($urandom_range(1, 5));
      tick();
      if (bus.adapt_en) cyc++;
    end
    bus.freeze = 1'b0;
    check("train_len", cyc, exp_len);
    check("hold_state", bus.state, 5);
    check("hold_cnt", bus.train_cnt, exp_len - 1);
    check("hold_done", bus.done, 1);
    check("hold_out_valid", bus.out_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntr;
    int fz;
    int w;
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.start   = 1'b1;
    bus.freeze  = 1'b0;
    bus.abort   = 1'b0;
    bus.n_train = '0;
    repeat (3) tick();
    check("rst_state", bus.state, 0);
    check("rst_dp_reset", bus.dp_reset, 1);
    check("rst_adapt", bus.adapt_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_train_cnt", bus.train_cnt, 0);
    check("rst_lut_en", bus.lut_wr_en, 0);
    reset     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("idle_after_rst", bus.state, 0);

    run_init(100);
    train_episode(100, 0, 1'b1);

    bus.freeze = 1'b1;
    tick();
    bus.freeze = 1'b0;
    tick();
    check("hold_freeze_ignored", bus.state, 5);
    check("hold_cnt_kept", bus.train_cnt, 99);

    resume(0);
    train_episode(0, 500, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ntr = int'($urandom_range(1, 60));
      case (i % 3)
        0:       fz = 0;
        1:       fz = ntr;
        default: fz = int'($urandom_range(1, 60));
      endcase
      resume(ntr);
      train_episode(ntr, fz, (i % 2) == 1);
    end

    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_hold_state", bus.state, 0);
    check("abort_hold_dp_reset", bus.dp_reset, 1);
    check("abort_hold_done", bus.done, 0);

    push_init();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    w = 0;
    while ((bus.lut_wr_addr != 5 || !bus.lut_wr_en) && w < 50) begin
      tick();
      w++;
    end
    check("abort_reach_addr5", w, 5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_initq_state", bus.state, 0);
    check("abort_initq_dp_reset", bus.dp_reset, 1);
    check("abort_initq_lut_en", bus.lut_wr_en, 0);
    check("abort_initq_busy", bus.busy, 0);
    exp_q.delete();
    tick();
    check("abort_stays_idle", bus.state, 0);

    run_init(30);
    train_episode(30, 0, 1'b0);

    resume(0);
    repeat (10) tick();
    reset     = 1'b0;
    bus.start = 1'b1;
    tick();
    check("midrst_state", bus.state, 0);
    check("midrst_dp_reset", bus.dp_reset, 1);
    check("midrst_adapt", bus.adapt_en, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_train_cnt", bus.train_cnt, 0);
    check("midrst_done", bus.done, 0);
    reset     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("post_rst_state", bus.state, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/saf_train_ctrl.md
Name: saf_train_ctrl

Overview:
- Sequencing controller for the spline adaptive filter datapath (Hammerstein SAF-LMS top).
- Steps a fixed sequence: hold the datapath in reset, load the spline control-point table with the identity ramp, load the linear FIR taps with a unit impulse, wait for the pipeline to fill, then enable LMS adaptation for a programmed number of samples before freezing.
- Sits between the host/testbench command interface and the datapath's reset, weight-write ports and adaptation-enable.

Parameters:
- L_ORD, 32, number of linear FIR taps.
- Q, 13, number of spline control points initialised.
- Q_ORD, 4, spline order + 1; only used to size the LUT address.
- WIDTH, 16, data word width (two's complement).
- QP, 12, fractional bits of the data format.
- DelX_inv, 2, log2 of 1/DelX (control-point spacing).
- FLUSH_LEN, 6, pipeline-fill cycles before adaptation; must be ≥1.
- CNT_W, 24, sample-counter width.
- SPAN_WIDTH, $clog2(Q+Q_ORD), spline LUT address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  single-cycle command pulse: begin init (IDLE) or resume training (HOLD).
- freeze  in  1  stop adaptation; TRAIN moves to HOLD.
- abort  in  1  return to IDLE from any state.
- n_train  in  CNT_W  training length in samples; 0 = unbounded (ends only on freeze).
- dp_reset  out  1  active-high reset to the datapath.
- lut_wr_en  out  1  spline control-point write strobe.
- lut_wr_addr  out  SPAN_WIDTH  control-point index.
- lut_wr_data  out  WIDTH  control-point value.
- lin_wr_en  out  1  linear tap write strobe.
- lin_wr_addr  out  $clog2(L_ORD)  tap index.
- lin_wr_data  out  WIDTH  tap value.
- adapt_en  out  1  enables the w and q LMS updates.
- out_valid  out  1  filter_out_d / error_d are meaningful.
- busy  out  1  state is INIT_Q, INIT_W or FLUSH.
- done  out  1  state is HOLD.
- state  out  3  encoding: IDLE=0, INIT_Q=1, INIT_W=2, FLUSH=3, TRAIN=4, HOLD=5.
- train_cnt  out  CNT_W  samples trained since entering TRAIN.

Behaviour:
- Register timing: every output is a register, so each output reflects the state entered at the preceding clock edge.
- Reset (reset=0 at an edge): state=IDLE, dp_reset=1, all other outputs 0, internal counters 0.
- Priority: reset > abort > freeze > start > terminal-count events. abort in any non-IDLE state → IDLE at the next edge; any write in flight is dropped; dp_reset=1.
- IDLE:
  - dp_reset=1; all write strobes and adapt_en = 0.
  - start=1 → INIT_Q with index k=0.
- INIT_Q:
  - dp_reset=0; lut_wr_en=1 for exactly Q consecutive cycles.
  - lut_wr_addr=k for k=0..Q-1.
  - lut_wr_data=(k-(Q-1)/2)<<(QP-DelX_inv), truncated to WIDTH, two's complement. This is the identity spline y=x.
  - After k=Q-1 → INIT_W with index 0.
- INIT_W:
  - lin_wr_en=1 for exactly L_ORD cycles, addr 0..L_ORD-1.
  - lin_wr_data=1<<QP at addr 0, otherwise 0.
  - After the last tap → FLUSH.
- FLUSH:
  - adapt_en=0, out_valid=0.
  - Stays exactly FLUSH_LEN cycles → TRAIN.
- TRAIN:
  - adapt_en=1, out_valid=1.
  - train_cnt is cleared on entry, then increments by 1 per cycle; it saturates at all-ones.
  - → HOLD when freeze=1, or when n_train≠0 and train_cnt==n_train-1 at the edge.
  - So exactly n_train cycles have adapt_en=1.
  - n_train is sampled on entry to TRAIN; later changes are ignored until the next entry.
- HOLD:
  - adapt_en=0, out_valid=1, done=1; train_cnt holds its final value.
  - start → TRAIN (counter cleared, no re-init).
  - freeze is ignored in HOLD.
- Commands outside their states:
  - start in INIT_Q/INIT_W/FLUSH/TRAIN is ignored.
  - freeze outside TRAIN is ignored.
- Simultaneous events:
  - abort+start in HOLD → IDLE.
  - freeze on the same edge as the terminal count → HOLD, counted once.
- Write strobes: lut_wr_en and lin_wr_en are never both 1 in the same cycle.
- busy is high only in INIT_Q, INIT_W and FLUSH.

Test Plan:
- Reset then start (defaults) → lut writes addr 0..12 with data 0xE800, 0xEC00, …, 0x0000 at addr 6, …, 0x1800. Then 32 lin writes with 0x1000 at addr 0 and 0 elsewhere. Then 6 cycles of FLUSH, then TRAIN. adapt_en rises exactly 1+13+32+6 cycles after the start edge.
- n_train=100 → adapt_en high exactly 100 cycles; train_cnt=99 in HOLD; done=1, out_valid=1.
- n_train=0, freeze asserted after 500 TRAIN cycles → HOLD. Then start → TRAIN with train_cnt restarting at 0 and no lut/lin writes.
- abort asserted at lut_wr_addr=5 → next cycle IDLE, dp_reset=1, lut_wr_en=0. A subsequent start restarts at addr 0.
- reset=0 asserted mid-TRAIN for 1 cycle → IDLE with all outputs at reset values; start is ignored while reset=0.
- freeze during INIT_W and start during FLUSH → both ignored; the sequence timing is unchanged.
